vio_host_port: RTL and testbench
================================

Name: vio_host_port

Overview:
- Host-side port of the vIO Switch. It terminates the per-region host data path of every vFIU.
- TX direction: packet-granular round-robin merge of N_REGIONS host_tx_to_switch streams into one DMA-bound stream.
- RX direction: splits the single DMA-return stream back into per-region host_rx_from_switch streams, steered by tdest.
- Sits between the vFIU array and the DMA engine inside nf_composer_top.

Parameters:
- N_REGIONS, 4, number of vFPGA regions; power of two, range 2..16.
- DATA_BITS, 512, AXI stream data width (AXI_DATA_BITS).
- ID_BITS, 6, tid width (PID_BITS).
- DEST_BITS, 14, tdest / route width.
- RB, $clog2(N_REGIONS), region index width (derived, not overridable).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_tx_tvalid  in  N_REGIONS  per-region TX valid (from vFIU host_tx_to_switch).
- s_tx_tready  out  N_REGIONS  per-region TX ready.
- s_tx_tdata  in  N_REGIONS*DATA_BITS  TX data, region i at slice i.
- s_tx_tkeep  in  N_REGIONS*DATA_BITS/8  TX keep.
- s_tx_tlast  in  N_REGIONS  TX last.
- s_tx_tid  in  N_REGIONS*ID_BITS  TX tid.
- s_tx_tdest  in  N_REGIONS*DEST_BITS  TX tdest.
- m_tx_tvalid/tready/tdata/tkeep/tlast/tid/tdest  out/in/out...  1/1/DATA_BITS/DATA_BITS/8/1/ID_BITS/DEST_BITS  merged TX toward DMA.
- m_tx_tsrc  out  RB  source region of the current beat.
- s_rx_tvalid/tready/tdata/tkeep/tlast/tid/tdest  in/out/in...  single RX stream from DMA.
- m_rx_tvalid  out  N_REGIONS  per-region RX valid (to vFIU host_rx_from_switch).
- m_rx_tready  in  N_REGIONS  per-region RX ready.
- m_rx_tdata/tkeep/tlast/tid/tdest  out  N_REGIONS*width  per-region RX payload.
- tx_pkt_cnt  out  32  TX packets completed (tlast handshakes on m_tx).
- rx_drop_cnt  out  32  RX packets discarded for an invalid destination.

Behaviour:

Reset (async assert, sync deassert):
- All valid outputs 0; all s_*_tready 0.
- Counters 0; TX FSM in TX_IDLE; RX FSM in RX_HEAD; last_grant = N_REGIONS-1, so region 0 wins first.

TX FSM (TX_IDLE, TX_LOCK):
- TX_IDLE: from the valid requesters, grant the first at or after (last_grant+1) mod N_REGIONS, searching with wrap. Enter TX_LOCK in the same cycle.
- TX_LOCK: only the granted region's tready may be 1; all other s_tx_tready stay 0.
- On the granted region's tlast handshake: update last_grant, return to TX_IDLE. The next grant may occur the cycle after.
- Output stage: 2-entry skid buffer. An input handshake at cycle t gives m_tx_tvalid at t+1.
- Full throughput of 1 beat/cycle within a packet. The skid buffer absorbs a single-cycle drop of m_tx_tready with no bubble.
- s_tx_tready(grant) = skid buffer not full.
- m_tx_tsrc travels with each beat.
- Rule: a packet is never interleaved with another packet.

tx_pkt_cnt:
- Increments on m_tx_tvalid & m_tx_tready & m_tx_tlast.
- Saturates at 0xFFFFFFFF.

RX FSM (RX_HEAD, RX_FWD, RX_DROP):
- Sample idx = s_rx_tdest[RB-1:0] on the first beat only.
- Any set bit in s_rx_tdest[DEST_BITS-1:RB] marks the destination invalid.
- RX_HEAD, first beat valid and destination valid: latch idx, forward the beat, go to RX_FWD. If that first beat carries tlast, stay in RX_HEAD.
- RX_HEAD, first beat valid and destination invalid: enter RX_DROP, with s_rx_tready=1 for the whole packet including the head beat. On tlast, rx_drop_cnt increments (saturating) and the FSM returns to RX_HEAD.
- RX_FWD: later beats go to the latched idx regardless of their tdest. tlast returns the FSM to RX_HEAD.
- RX output: one register stage per packet stream, steered to the latched region.
  - Latency: 1 cycle.
  - s_rx_tready = (output register empty) | m_rx_tready[idx].
  - Only m_rx_tvalid[idx] is ever asserted; all other regions' payload outputs hold 0.

Independence and boundaries:
- TX and RX paths share no state and run concurrently.
- A region may stall m_rx_tready indefinitely. This backpressures DMA only and never affects TX.
- Reset mid-packet: partial beats are discarded. After reset, the next beat on s_rx is treated as a head.

Test Plan:
- Regions 0 and 2 each present a 3-beat packet at cycle 0 -> m_tx carries region 0's beats (tsrc=0), then region 2's (tsrc=2), no interleave; tx_pkt_cnt=2; first m_tx_tvalid one cycle after the first input handshake.
- All 4 regions continuously send 1-beat packets -> grant order 0,1,2,3,0,1… with one grant per packet; tdata/tid/tdest are preserved bit-exact.
- m_tx_tready toggles 1,0,1,0 during an 8-beat region-1 packet -> all 8 beats delivered in order; no duplicated or lost beat; other regions' tready stay 0 until tlast.
- RX 4-beat packet, head tdest=0x0003, later beats tdest=0x0001 -> all 4 beats appear only on m_rx[3]; m_rx_tvalid[0..2] stay 0.
- RX packet with tdest=0x0010 (N_REGIONS=4) -> s_rx_tready held 1, no m_rx_tvalid, rx_drop_cnt 0→1. The next packet with tdest=0x0002 is delivered to region 2.
- aresetn pulsed low mid-packet on both paths -> all valids and readies go to 0 immediately; counters 0; region 0 wins the first post-reset TX grant.

Source files
------------

// File: rtl/vio_host_port_if.sv
`default_nettype none
// ============================================================================
// Module      : vio_host_port_if
// Description : Bundled AXI-stream lanes (N parallel streams) for vio_host_port.
// Revision    : 1.0 - initial release
// ============================================================================
interface vio_host_port_if #(
    parameter int N         = 1,
    parameter int DATA_BITS = 512,
    parameter int ID_BITS   = 6,
    parameter int DEST_BITS = 14
);
    logic [N-1:0]               tvalid;
    logic [N-1:0]               tready;
    logic [N*DATA_BITS-1:0]     tdata;
    logic [N*DATA_BITS/8-1:0]   tkeep;
    logic [N-1:0]               tlast;
    logic [N*ID_BITS-1:0]       tid;
    logic [N*DEST_BITS-1:0]     tdest;

    modport master (
        output tvalid, tdata, tkeep, tlast, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tid, tdest,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/vio_host_port.sv
`default_nettype none
// ============================================================================
// Module      : vio_host_port
// Description : vIO switch host port: packet round-robin TX merge, tdest RX split.
// Revision    : 1.0 - initial release
// ============================================================================
module vio_host_port #(
    parameter int N_REGIONS  = 4,
    parameter int DATA_BITS  = 512,
    parameter int ID_BITS    = 6,
    parameter int DEST_BITS  = 14,
    localparam int RB        = $clog2(N_REGIONS)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    vio_host_port_if.slave       s_tx,
    vio_host_port_if.master      m_tx,
    vio_host_port_if.slave       s_rx,
    vio_host_port_if.master      m_rx,
    output logic [RB-1:0]        m_tx_tsrc,
    output logic [31:0]          tx_pkt_cnt,
    output logic [31:0]          rx_drop_cnt
);

    localparam int c_keep_bits = DATA_BITS / 8;

    typedef struct packed {
        logic [RB-1:0]          src;
        logic [DEST_BITS-1:0]   dest;
        logic [ID_BITS-1:0]     id;
        logic                   last;
        logic [c_keep_bits-1:0] keep;
        logic [DATA_BITS-1:0]   data;
    } tx_beat_t;

    typedef struct packed {
        logic [DEST_BITS-1:0]   dest;
        logic [ID_BITS-1:0]     id;
        logic                   last;
        logic [c_keep_bits-1:0] keep;
        logic [DATA_BITS-1:0]   data;
    } rx_beat_t;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_LOCK = 1'b1
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_HEAD = 2'd0,
        RX_FWD  = 2'd1,
        RX_DROP = 2'd2
    } rx_state_t;

    // ------------------------------------------------------------------------
    // TX: arbiter + 2-entry skid buffer
    // ------------------------------------------------------------------------
    tx_state_t      r_tx_state;
    logic [RB-1:0]  r_last_grant;
    logic [RB-1:0]  r_grant;
    logic [RB-1:0]  w_pick;
    logic           w_any;
    logic [1:0]     r_tx_cnt;
    logic           r_tx_wptr;
    logic           r_tx_rptr;
    tx_beat_t       r_tx_mem [2];
    tx_beat_t       w_tx_in;
    tx_beat_t       w_tx_head;
    logic           w_tx_full;
    logic           w_tx_push;
    logic           w_tx_pop;

    // Search starts just past the previous winner and wraps, so every region
    // is reached within N_REGIONS grants.
    always_comb begin
        w_pick = r_last_grant;
        w_any  = 1'b0;
        for (int k = 1; k <= N_REGIONS; k++) begin
            if (!w_any && s_tx.tvalid[RB'(r_last_grant + RB'(k))]) begin
                w_pick = RB'(r_last_grant + RB'(k));
                w_any  = 1'b1;
            end
        end
    end

    assign w_tx_full = (r_tx_cnt == 2'd2);
    assign w_tx_push = (r_tx_state == TX_LOCK) && !w_tx_full && s_tx.tvalid[r_grant];
    assign w_tx_pop  = (r_tx_cnt != 2'd0) && m_tx.tready[0];
    assign w_tx_head = r_tx_mem[r_tx_rptr];

    always_comb begin
        w_tx_in.src  = r_grant;
        w_tx_in.dest = s_tx.tdest[r_grant*DEST_BITS +: DEST_BITS];
        w_tx_in.id   = s_tx.tid[r_grant*ID_BITS +: ID_BITS];
        w_tx_in.last = s_tx.tlast[r_grant];
        w_tx_in.keep = s_tx.tkeep[r_grant*c_keep_bits +: c_keep_bits];
        w_tx_in.data = s_tx.tdata[r_grant*DATA_BITS +: DATA_BITS];
    end

    for (genvar i = 0; i < N_REGIONS; i++) begin : g_tx_ready
        assign s_tx.tready[i] = (r_tx_state == TX_LOCK) && (r_grant == RB'(i)) && !w_tx_full;
    end

    assign m_tx.tvalid[0] = (r_tx_cnt != 2'd0);
    assign m_tx.tdata     = w_tx_head.data;
    assign m_tx.tkeep     = w_tx_head.keep;
    assign m_tx.tlast[0]  = w_tx_head.last;
    assign m_tx.tid       = w_tx_head.id;
    assign m_tx.tdest     = w_tx_head.dest;
    assign m_tx_tsrc      = w_tx_head.src;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tx_state   <= TX_IDLE;
            r_last_grant <= RB'(N_REGIONS - 1);
            r_grant      <= '0;
            r_tx_cnt     <= 2'd0;
            r_tx_wptr    <= 1'b0;
            r_tx_rptr    <= 1'b0;
            tx_pkt_cnt   <= 32'd0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_any) begin
                        r_grant    <= w_pick;
                        r_tx_state <= TX_LOCK;
                    end
                end
                TX_LOCK: begin
                    if (w_tx_push && s_tx.tlast[r_grant]) begin
                        r_last_grant <= r_grant;
                        r_tx_state   <= TX_IDLE;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase

            if (w_tx_push) r_tx_wptr <= ~r_tx_wptr;
            if (w_tx_pop)  r_tx_rptr <= ~r_tx_rptr;
            r_tx_cnt <= r_tx_cnt + {1'b0, w_tx_push} - {1'b0, w_tx_pop};

            if (w_tx_pop && w_tx_head.last && (tx_pkt_cnt != 32'hFFFF_FFFF))
                tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= w_tx_in;
    end

    // ------------------------------------------------------------------------
    // RX: head decode, steering register, drop of bad destinations
    // ------------------------------------------------------------------------
    rx_state_t      r_rx_state;
    logic           r_rx_en;
    logic           r_rx_valid;
    logic [RB-1:0]  r_rx_idx;
    rx_beat_t       r_rx_beat;
    rx_beat_t       w_rx_in;
    logic           w_rx_bad;
    logic           w_rx_space;
    logic           w_rx_ready;
    logic           w_rx_hs;
    logic           w_rx_load;
    logic           w_rx_drop_done;

    assign w_rx_bad   = |s_rx.tdest[DEST_BITS-1:RB];
    assign w_rx_space = !r_rx_valid || m_rx.tready[r_rx_idx];

    // r_rx_en keeps tready low while reset is held and for the release cycle.
    always_comb begin
        w_rx_ready = 1'b0;
        if (r_rx_en) begin
            case (r_rx_state)
                RX_HEAD: w_rx_ready = w_rx_bad ? 1'b1 : w_rx_space;
                RX_FWD:  w_rx_ready = w_rx_space;
                RX_DROP: w_rx_ready = 1'b1;
                default: w_rx_ready = 1'b0;
            endcase
        end
    end

    assign s_rx.tready[0]  = w_rx_ready;
    assign w_rx_hs         = s_rx.tvalid[0] && w_rx_ready;
    assign w_rx_load       = w_rx_hs && (((r_rx_state == RX_HEAD) && !w_rx_bad) ||
                                         (r_rx_state == RX_FWD));
    assign w_rx_drop_done  = w_rx_hs && s_rx.tlast[0] &&
                             ((r_rx_state == RX_DROP) || ((r_rx_state == RX_HEAD) && w_rx_bad));

    always_comb begin
        w_rx_in.dest = s_rx.tdest;
        w_rx_in.id   = s_rx.tid;
        w_rx_in.last = s_rx.tlast[0];
        w_rx_in.keep = s_rx.tkeep;
        w_rx_in.data = s_rx.tdata;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rx_state  <= RX_HEAD;
            r_rx_en     <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_idx    <= '0;
            rx_drop_cnt <= 32'd0;
        end else begin
            r_rx_en <= 1'b1;
            case (r_rx_state)
                RX_HEAD: begin
                    if (w_rx_hs) begin
                        if (w_rx_bad) begin
                            if (!s_rx.tlast[0]) r_rx_state <= RX_DROP;
                        end else begin
                            r_rx_idx <= s_rx.tdest[RB-1:0];
                            if (!s_rx.tlast[0]) r_rx_state <= RX_FWD;
                        end
                    end
                end
                RX_FWD: begin
                    if (w_rx_hs && s_rx.tlast[0]) r_rx_state <= RX_HEAD;
                end
                RX_DROP: begin
                    if (w_rx_hs && s_rx.tlast[0]) r_rx_state <= RX_HEAD;
                end
                default: r_rx_state <= RX_HEAD;
            endcase

            if (w_rx_load)       r_rx_valid <= 1'b1;
            else if (w_rx_space) r_rx_valid <= 1'b0;

            if (w_rx_drop_done && (rx_drop_cnt != 32'hFFFF_FFFF))
                rx_drop_cnt <= rx_drop_cnt + 32'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_rx_load) r_rx_beat <= w_rx_in;
    end

    // Unselected regions see an all-zero payload.
    for (genvar i = 0; i < N_REGIONS; i++) begin : g_rx_out
        logic w_sel;
        assign w_sel = r_rx_valid && (r_rx_idx == RB'(i));
        assign m_rx.tvalid[i]                                 = w_sel;
        assign m_rx.tdata[i*DATA_BITS +: DATA_BITS]           = w_sel ? r_rx_beat.data : '0;
        assign m_rx.tkeep[i*c_keep_bits +: c_keep_bits]       = w_sel ? r_rx_beat.keep : '0;
        assign m_rx.tlast[i]                                  = w_sel && r_rx_beat.last;
        assign m_rx.tid[i*ID_BITS +: ID_BITS]                 = w_sel ? r_rx_beat.id : '0;
        assign m_rx.tdest[i*DEST_BITS +: DEST_BITS]           = w_sel ? r_rx_beat.dest : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_vio_host_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_vio_host_port
// Description : Directed self-checking bench for vio_host_port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vio_host_port;

    localparam int N   = 4;
    localparam int DW  = 512;
    localparam int KW  = DW / 8;
    localparam int IW  = 6;
    localparam int DSW = 14;
    localparam int RB  = 2;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    vio_host_port_if #(.N(N), .DATA_BITS(DW), .ID_BITS(IW), .DEST_BITS(DSW)) stx ();
    vio_host_port_if #(.N(1), .DATA_BITS(DW), .ID_BITS(IW), .DEST_BITS(DSW)) mtx ();
    vio_host_port_if #(.N(1), .DATA_BITS(DW), .ID_BITS(IW), .DEST_BITS(DSW)) srx ();
    vio_host_port_if #(.N(N), .DATA_BITS(DW), .ID_BITS(IW), .DEST_BITS(DSW)) mrx ();

    logic [RB-1:0] m_tx_tsrc;
    logic [31:0]   tx_pkt_cnt;
    logic [31:0]   rx_drop_cnt;

    vio_host_port #(
        .N_REGIONS (N),
        .DATA_BITS (DW),
        .ID_BITS   (IW),
        .DEST_BITS (DSW)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_tx        (stx),
        .m_tx        (mtx),
        .s_rx        (srx),
        .m_rx        (mrx),
        .m_tx_tsrc   (m_tx_tsrc),
        .tx_pkt_cnt  (tx_pkt_cnt),
        .rx_drop_cnt (rx_drop_cnt)
    );

    typedef struct {
        int          src;
        logic [31:0] data;
        logic [5:0]  id;
        logic [13:0] dest;
        logic        last;
    } tx_rec_t;

    typedef struct {
        int          region;
        logic [31:0] data;
    } rx_rec_t;

    typedef struct {
        logic [13:0] dest;
        logic        last;
        logic [31:0] data;
        logic        drop;
    } rx_beat_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int       tx_pkts [N];
    int       tx_len  [N];
    int       tx_pos  [N];
    int       tx_seq  [N];
    logic [N-1:0] tx_hs;
    logic     rx_hs;
    logic     toggle_rdy = 1'b0;

    rx_beat_t rx_q [$];
    tx_rec_t  txq  [$];
    rx_rec_t  rxq  [$];

    int first_hs_cyc  = -1;
    int first_vld_cyc = -1;
    int rx_leak       = 0;
    int drop_stall    = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] tx_tag(input int region, input int seq);
        return {8'hA0, 8'(region), 16'(seq)};
    endfunction

    // Output monitors
    always @(negedge aclk) begin
        if (mtx.tvalid[0] && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (mtx.tvalid[0] && mtx.tready[0])
            txq.push_back('{int'(m_tx_tsrc), mtx.tdata[31:0], mtx.tid, mtx.tdest, mtx.tlast[0]});
        for (int i = 0; i < N; i++) begin
            if (mrx.tvalid[i] && mrx.tready[i])
                rxq.push_back('{i, mrx.tdata[i*DW +: 32]});
            if (!mrx.tvalid[i] && ((mrx.tdata[i*DW +: DW] != '0) || (mrx.tdest[i*DSW +: DSW] != '0)))
                rx_leak++;
        end
        if ($countones(mrx.tvalid) > 1) rx_leak++;
    end

    task automatic drive_all();
        for (int i = 0; i < N; i++) begin
            stx.tvalid[i]             = (tx_pkts[i] > 0);
            stx.tdata[i*DW +: DW]     = DW'(tx_tag(i, tx_seq[i]));
            stx.tkeep[i*KW +: KW]     = '1;
            stx.tlast[i]              = (tx_pos[i] == tx_len[i] - 1);
            stx.tid[i*IW +: IW]       = IW'(i * 4 + tx_seq[i]);
            stx.tdest[i*DSW +: DSW]   = DSW'(i * 256 + tx_seq[i]);
        end
        srx.tkeep = '1;
        srx.tid   = '0;
        if (rx_q.size() > 0) begin
            srx.tvalid[0] = 1'b1;
            srx.tdata     = DW'(rx_q[0].data);
            srx.tdest     = rx_q[0].dest;
            srx.tlast[0]  = rx_q[0].last;
        end else begin
            srx.tvalid[0] = 1'b0;
            srx.tdata     = '0;
            srx.tdest     = '0;
            srx.tlast[0]  = 1'b0;
        end
    endtask

    task automatic tx_load(input int region, input int pkts, input int len);
        tx_pkts[region] = pkts;
        tx_len[region]  = len;
        tx_pos[region]  = 0;
        tx_seq[region]  = 0;
    endtask

    task automatic rx_push(input logic [13:0] dest, input logic last, input logic [31:0] data,
                           input logic drop);
        rx_q.push_back('{dest, last, data, drop});
    endtask

    task automatic tick();
        @(negedge aclk);
        for (int i = 0; i < N; i++) tx_hs[i] = stx.tvalid[i] && stx.tready[i];
        rx_hs = srx.tvalid[0] && srx.tready[0];
        if ((tx_hs != '0) && first_hs_cyc < 0) first_hs_cyc = cyc;
        if (srx.tvalid[0] && rx_q.size() > 0 && rx_q[0].drop && !srx.tready[0]) drop_stall++;
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (tx_hs[i]) begin
                tx_seq[i]++;
                tx_pos[i]++;
                if (tx_pos[i] == tx_len[i]) begin
                    tx_pos[i] = 0;
                    tx_pkts[i]--;
                end
            end
        end
        if (rx_hs && rx_q.size() > 0) void'(rx_q.pop_front());
        if (toggle_rdy) mtx.tready[0] = ~mtx.tready[0];
        drive_all();
    endtask

    // Asserts reset at the current time, checks the idle state, then releases.
    task automatic apply_reset(input string tag);
        aresetn = 1'b0;
        #1;
        check({tag, "_m_tx_tvalid"}, 64'(mtx.tvalid), 64'd0);
        check({tag, "_s_tx_tready"}, 64'(stx.tready), 64'd0);
        check({tag, "_s_rx_tready"}, 64'(srx.tready), 64'd0);
        check({tag, "_m_rx_tvalid"}, 64'(mrx.tvalid), 64'd0);
        check({tag, "_tx_pkt_cnt"},  64'(tx_pkt_cnt), 64'd0);
        check({tag, "_rx_drop_cnt"}, 64'(rx_drop_cnt), 64'd0);
        for (int i = 0; i < N; i++) tx_load(i, 0, 1);
        rx_q.delete();
        toggle_rdy    = 1'b0;
        mtx.tready[0] = 1'b1;
        mrx.tready    = '1;
        drive_all();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        txq.delete();
        rxq.delete();
        first_hs_cyc  = -1;
        first_vld_cyc = -1;
        rx_leak       = 0;
    endtask

    task automatic run_tx(input string tag, input int n, input int budget);
        int c = 0;
        while (txq.size() < n && c < budget) begin
            tick();
            c++;
        end
        repeat (4) tick();
        check({tag, "_tx_beats"}, 64'(txq.size()), 64'(n));
    endtask

    task automatic run_rx(input string tag, input int n, input int budget);
        int c = 0;
        while ((rxq.size() < n || rx_q.size() > 0) && c < budget) begin
            tick();
            c++;
        end
        repeat (4) tick();
        check({tag, "_rx_beats"}, 64'(rxq.size()), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_src [10];
        int exp_seq [10];
        int c;

        for (int i = 0; i < N; i++) tx_load(i, 0, 1);
        mtx.tready = 1'b1;
        mrx.tready = '1;
        drive_all();
        @(posedge aclk);
        #1;

        // 1: two 3-beat packets, regions 0 and 2
        apply_reset("rst0");
        tx_load(0, 1, 3);
        tx_load(2, 1, 3);
        run_tx("t1", 6, 60);
        for (int k = 0; k < 6 && k < txq.size(); k++) begin
            check("t1_src",  64'(txq[k].src),  (k < 3) ? 64'd0 : 64'd2);
            check("t1_data", 64'(txq[k].data), 64'(tx_tag((k < 3) ? 0 : 2, k % 3)));
            check("t1_last", 64'(txq[k].last), 64'((k % 3) == 2));
        end
        check("t1_pkt_cnt", 64'(tx_pkt_cnt), 64'd2);
        check("t1_latency", 64'(first_vld_cyc - first_hs_cyc), 64'd1);

        // 2: all regions stream 1-beat packets
        @(posedge aclk);
        #1;
        apply_reset("rst1");
        for (int i = 0; i < N; i++) tx_load(i, 2, 1);
        run_tx("t2", 8, 80);
        for (int k = 0; k < 8 && k < txq.size(); k++) begin
            check("t2_src",  64'(txq[k].src),  64'(k % 4));
            check("t2_data", 64'(txq[k].data), 64'(tx_tag(k % 4, k / 4)));
            check("t2_id",   64'(txq[k].id),   64'((k % 4) * 4 + k / 4));
            check("t2_dest", 64'(txq[k].dest), 64'((k % 4) * 256 + k / 4));
        end
        check("t2_pkt_cnt", 64'(tx_pkt_cnt), 64'd8);

        // 3: 8-beat region-1 packet under toggling m_tx_tready
        @(posedge aclk);
        #1;
        apply_reset("rst2");
        tx_load(1, 1, 8);
        toggle_rdy = 1'b1;
        tick();
        tick();
        tx_load(0, 1, 1);
        tx_load(3, 1, 1);
        c = 0;
        while (tx_pkts[1] > 0 && c < 60) begin
            tick();
            check("t3_other_rdy", 64'(stx.tready & 4'b1101), 64'd0);
            c++;
        end
        toggle_rdy    = 1'b0;
        mtx.tready[0] = 1'b1;
        run_tx("t3", 10, 60);
        for (int k = 0; k < 8; k++) begin
            exp_src[k] = 1;
            exp_seq[k] = k;
        end
        exp_src[8] = 3; exp_seq[8] = 0;
        exp_src[9] = 0; exp_seq[9] = 0;
        for (int k = 0; k < 10 && k < txq.size(); k++) begin
            check("t3_src",  64'(txq[k].src),  64'(exp_src[k]));
            check("t3_data", 64'(txq[k].data), 64'(tx_tag(exp_src[k], exp_seq[k])));
        end

        // 4: RX packet steered by head tdest only
        @(posedge aclk);
        #1;
        apply_reset("rst3");
        rx_push(14'h0003, 1'b0, 32'hB000_0000, 1'b0);
        rx_push(14'h0001, 1'b0, 32'hB000_0001, 1'b0);
        rx_push(14'h0001, 1'b0, 32'hB000_0002, 1'b0);
        rx_push(14'h0001, 1'b1, 32'hB000_0003, 1'b0);
        run_rx("t4", 4, 40);
        for (int k = 0; k < 4 && k < rxq.size(); k++) begin
            check("t4_region", 64'(rxq[k].region), 64'd3);
            check("t4_data",   64'(rxq[k].data),   64'(32'hB000_0000 + k));
        end
        check("t4_leak", 64'(rx_leak), 64'd0);

        // 5: invalid destination dropped, following packet delivered
        rxq.delete();
        drop_stall = 0;
        check("t5_drop_before", 64'(rx_drop_cnt), 64'd0);
        rx_push(14'h0010, 1'b0, 32'hC000_0000, 1'b1);
        rx_push(14'h0010, 1'b0, 32'hC000_0001, 1'b1);
        rx_push(14'h0010, 1'b1, 32'hC000_0002, 1'b1);
        rx_push(14'h0002, 1'b0, 32'hD000_0000, 1'b0);
        rx_push(14'h0000, 1'b1, 32'hD000_0001, 1'b0);
        run_rx("t5", 2, 40);
        for (int k = 0; k < 2 && k < rxq.size(); k++) begin
            check("t5_region", 64'(rxq[k].region), 64'd2);
            check("t5_data",   64'(rxq[k].data),   64'(32'hD000_0000 + k));
        end
        check("t5_drop_after", 64'(rx_drop_cnt), 64'd1);
        check("t5_drop_stall", 64'(drop_stall), 64'd0);
        check("t5_leak", 64'(rx_leak), 64'd0);

        // 6: reset in the middle of packets on both paths
        txq.delete();
        tx_load(0, 1, 1);
        run_tx("t6_pre", 1, 20);
        check("t6_pre_pkt_cnt", 64'(tx_pkt_cnt), 64'd1);
        tx_load(2, 1, 8);
        for (int k = 0; k < 6; k++) rx_push(14'h0001, k == 5, 32'hE000_0000 + k, 1'b0);
        repeat (4) tick();
        apply_reset("rst_mid");
        tx_load(0, 1, 1);
        tx_load(1, 1, 1);
        rx_push(14'h0002, 1'b1, 32'hF000_0000, 1'b0);
        run_tx("t6", 2, 40);
        if (txq.size() >= 2) begin
            check("t6_first_src",  64'(txq[0].src), 64'd0);
            check("t6_second_src", 64'(txq[1].src), 64'd1);
        end
        run_rx("t6", 1, 40);
        if (rxq.size() >= 1) begin
            check("t6_rx_region", 64'(rxq[0].region), 64'd2);
            check("t6_rx_data",   64'(rxq[0].data),   64'(32'hF000_0000));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
